i2c_poll_sequencer: RTL and testbench

//  Avalon-MM master sitting directly upstream of the I2C Avalon bridge slave; autonomously polls up to NUM_SLOTS
//  I2C devices: per slot writes a register pointer, then reads N bytes, drains the bridge read FIFO and streams
//  the words out with slot tags. Replaces per-sample CPU register banging; CPU only loads the slot table.

---
 rtl/i2c_poll_sequencer_if.sv | 33 +++
 rtl/i2c_poll_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_poll_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_poll_sequencer_if.sv
// Avalon-MM master bus toward the I2C bridge plus the tagged result stream.
// Handshakes: an Avalon request (address/writedata/read/write) stays stable until the
// cycle with request & ~m_waitrequest; a result word stays stable until res_valid & res_ready.
interface i2c_poll_sequencer_if #(
  parameter int SLOT_W = 2
) ();
  logic [2:0]        m_address;
  logic              m_write;
  logic              m_read;
  logic [31:0]       m_writedata;
  logic [31:0]       m_readdata;
  logic              m_waitrequest;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;
  logic [SLOT_W-1:0] res_slot;
  logic              res_last;
  logic              res_error;

  modport master (
    output m_address, m_write, m_read, m_writedata,
    input  m_readdata, m_waitrequest,
    output res_valid, res_data, res_slot, res_last, res_error,
    input  res_ready
  );

  modport slave (
    input  m_address, m_write, m_read, m_writedata,
    output m_readdata, m_waitrequest,
    input  res_valid, res_data, res_slot, res_last, res_error,
    output res_ready
  );
endinterface

// File: rtl/i2c_poll_sequencer.sv
// Autonomous poller: per enabled slot writes a register pointer through the I2C bridge,
// reads the requested bytes, drains the bridge FIFO and streams the words with slot tags.
module i2c_poll_sequencer #(
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_W      = 2,
  parameter int POLL_PERIOD = 50000,
  parameter int WAIT_LIMIT  = 65535
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic [6:0]        cfg_addr,
  input  logic [7:0]        cfg_reg,
  input  logic [7:0]        cfg_nbytes,
  i2c_poll_sequencer_if.master bus,
  output logic              busy,
  output logic              round_done,
  output logic              timeout_err,
  output logic [4:0]        state_dbg
);

  localparam int PER_W  = $clog2(POLL_PERIOD) + 1;
  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [4:0] {
    S_IDLE, S_SCAN, S_W_ADDR, S_W_RW0, S_W_PTR, S_W_NB1, S_W_ENA0, S_POLL_W, S_ACK_W,
    S_W_RW1, S_W_NBN, S_W_ENA1, S_POLL_R, S_ACK_R, S_RD_USED, S_POP, S_EMIT, S_NEXT
  } state_t;

  state_t state, state_d;

  logic [6:0]        tbl_addr [NUM_SLOTS];
  logic [7:0]        tbl_reg  [NUM_SLOTS];
  logic [7:0]        tbl_nb   [NUM_SLOTS];
  logic [SLOT_W-1:0] slot_q;
  logic [6:0]        l_addr;
  logic [7:0]        l_reg;
  logic [7:0]        l_nb;
  logic [15:0]       cnt_q;
  logic [31:0]       res_data_q;
  logic              res_last_q;
  logic              res_err_q;
  logic [PER_W-1:0]  period_cnt;
  logic              pending;
  logic [WAIT_W-1:0] wait_cnt;

  logic [2:0]  m_address_c;
  logic [31:0] m_writedata_c;
  logic        m_write_c, m_read_c;
  logic        req, xfer_done, tick, last_slot, round_end;

  assign req       = m_write_c | m_read_c;
  assign xfer_done = req & ~bus.m_waitrequest;
  assign tick      = enable && (period_cnt == PER_W'(POLL_PERIOD - 1));
  assign last_slot = (slot_q == SLOT_W'(NUM_SLOTS - 1));

  assign bus.m_address   = m_address_c;
  assign bus.m_write     = m_write_c;
  assign bus.m_read      = m_read_c;
  assign bus.m_writedata = m_writedata_c;
  assign bus.res_valid   = (state == S_EMIT);
  assign bus.res_data    = res_data_q;
  assign bus.res_slot    = slot_q;
  assign bus.res_last    = res_last_q;
  assign bus.res_error   = res_err_q;
  assign busy            = (state != S_IDLE);
  assign state_dbg       = state;

  // Table writes land immediately; the slot in progress works from its latched copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        tbl_addr[i] <= '0;
        tbl_reg[i]  <= '0;
        tbl_nb[i]   <= '0;
      end
    end else if (cfg_we) begin
      tbl_addr[cfg_slot] <= cfg_addr;
      tbl_reg[cfg_slot]  <= cfg_reg;
      tbl_nb[cfg_slot]   <= cfg_nbytes;
    end
  end

  always_comb begin
    state_d       = state;
    m_address_c   = 3'd0;
    m_writedata_c = 32'd0;
    m_write_c     = 1'b0;
    m_read_c      = 1'b0;
    round_end     = 1'b0;
    case (state)
      S_IDLE:    if (enable && (tick || pending)) state_d = S_SCAN;
      S_SCAN: begin
        if (!enable) state_d = S_IDLE;
        else if (tbl_nb[slot_q] != 8'd0) state_d = S_W_ADDR;
        else if (last_slot) begin
          state_d   = S_IDLE;
          round_end = 1'b1;
        end
      end
      S_W_ADDR:  begin m_write_c = 1'b1; m_address_c = 3'd0; m_writedata_c = {25'd0, l_addr};
                       if (xfer_done) state_d = S_W_RW0; end
      S_W_RW0:   begin m_write_c = 1'b1; m_address_c = 3'd2;
                       if (xfer_done) state_d = S_W_PTR; end
      S_W_PTR:   begin m_write_c = 1'b1; m_address_c = 3'd1; m_writedata_c = {24'd0, l_reg};
                       if (xfer_done) state_d = S_W_NB1; end
      S_W_NB1:   begin m_write_c = 1'b1; m_address_c = 3'd4; m_writedata_c = 32'd1;
                       if (xfer_done) state_d = S_W_ENA0; end
      S_W_ENA0:  begin m_write_c = 1'b1; m_address_c = 3'd3; m_writedata_c = 32'd1;
                       if (xfer_done) state_d = S_POLL_W; end
      S_POLL_W:  begin m_read_c = 1'b1; m_address_c = 3'd3;
                       if (xfer_done && bus.m_readdata == 32'd0) state_d = S_ACK_W; end
      S_ACK_W:   begin m_read_c = 1'b1; m_address_c = 3'd5;
                       if (xfer_done) state_d = (bus.m_readdata != 32'd0) ? S_EMIT : S_W_RW1; end
      S_W_RW1:   begin m_write_c = 1'b1; m_address_c = 3'd2; m_writedata_c = 32'd1;
                       if (xfer_done) state_d = S_W_NBN; end
      S_W_NBN:   begin m_write_c = 1'b1; m_address_c = 3'd4; m_writedata_c = {24'd0, l_nb};
                       if (xfer_done) state_d = S_W_ENA1; end
      S_W_ENA1:  begin m_write_c = 1'b1; m_address_c = 3'd3; m_writedata_c = 32'd1;
                       if (xfer_done) state_d = S_POLL_R; end
      S_POLL_R:  begin m_read_c = 1'b1; m_address_c = 3'd3;
                       if (xfer_done && bus.m_readdata == 32'd0) state_d = S_ACK_R; end
      S_ACK_R:   begin m_read_c = 1'b1; m_address_c = 3'd5;
                       if (xfer_done) state_d = (bus.m_readdata != 32'd0) ? S_EMIT : S_RD_USED; end
      S_RD_USED: begin m_read_c = 1'b1; m_address_c = 3'd6;
                       if (xfer_done) state_d = (bus.m_readdata[15:0] == 16'd0) ? S_NEXT : S_POP; end
      S_POP:     begin m_read_c = 1'b1; m_address_c = 3'd1;
                       if (xfer_done) state_d = S_EMIT; end
      S_EMIT:    if (bus.res_ready) state_d = (res_err_q || res_last_q) ? S_NEXT : S_POP;
      S_NEXT: begin
        if (last_slot) begin
          state_d   = S_IDLE;
          round_end = 1'b1;
        end else if (!enable) state_d = S_IDLE;
        else state_d = S_SCAN;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      slot_q      <= '0;
      l_addr      <= '0;
      l_reg       <= '0;
      l_nb        <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
      res_err_q   <= 1'b0;
      period_cnt  <= '0;
      pending     <= 1'b0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      round_done  <= 1'b0;
    end else begin
      state      <= state_d;
      round_done <= round_end;

      if (!enable || tick) period_cnt <= '0;
      else                 period_cnt <= period_cnt + 1'b1;

      // Only one missed tick is remembered; it restarts the next round right after this one.
      if (!enable || state == S_IDLE) pending <= 1'b0;
      else if (tick)                  pending <= 1'b1;

      if (req && bus.m_waitrequest) begin
        if (wait_cnt != WAIT_W'(WAIT_LIMIT)) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WAIT_W'(WAIT_LIMIT - 1)) timeout_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        S_IDLE: slot_q <= '0;
        S_SCAN: if (enable) begin
          if (tbl_nb[slot_q] != 8'd0) begin
            l_addr <= tbl_addr[slot_q];
            l_reg  <= tbl_reg[slot_q];
            l_nb   <= tbl_nb[slot_q];
          end else if (!last_slot) begin
            slot_q <= slot_q + 1'b1;
          end
        end
        S_ACK_W, S_ACK_R: if (xfer_done && bus.m_readdata != 32'd0) begin
          res_err_q  <= 1'b1;
          res_data_q <= 32'd0;
          res_last_q <= 1'b1;
        end
        S_RD_USED: if (xfer_done) begin
          cnt_q     <= bus.m_readdata[15:0];
          res_err_q <= 1'b0;
        end
        // Pop everything the FIFO reports, even beyond nbytes, so the bridge is left empty.
        S_POP: if (xfer_done) begin
          res_data_q <= bus.m_readdata;
          res_last_q <= (cnt_q == 16'd1);
          cnt_q      <= cnt_q - 1'b1;
          res_err_q  <= 1'b0;
        end
        S_NEXT: if (!last_slot && enable) slot_q <= slot_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Bench for i2c_poll_sequencer: behavioural I2C bridge slave, result sink with
// back-pressure, table-driven single-slot rounds plus multi-cycle corner sequences.
module tb_i2c_poll_sequencer;
  localparam int W = 36;

  logic       clock, reset, enable, cfg_we;
  logic [1:0] cfg_slot;
  logic [6:0] cfg_addr;
  logic [7:0] cfg_reg, cfg_nbytes;
  logic       busy, round_done, timeout_err;
  logic [4:0] state_dbg;

  i2c_poll_sequencer_if #(.SLOT_W(2)) bus ();

  i2c_poll_sequencer #(.NUM_SLOTS(4), .SLOT_W(2), .POLL_PERIOD(40), .WAIT_LIMIT(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
    .cfg_addr(cfg_addr), .cfg_reg(cfg_reg), .cfg_nbytes(cfg_nbytes), .bus(bus),
    .busy(busy), .round_done(round_done), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- bookkeeping ----------------
  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [W-1:0] exp_bus_q[$], exp_res_q[$], bus_log[$], res_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // ---------------- bridge model and result sink ----------------
  int          cyc = 0, rd_cnt = 0, res_acc = 0, proto_viol = 0;
  bit          stuck_wait = 0, wait_pat = 1, prev_stall = 0;
  logic [36:0] prev_req;
  logic [6:0]  cur_dev;
  bit          cur_rw, poll_left;
  logic [31:0] fifo_q[$];
  int          dev_cnt [128];
  bit          dev_nak [128];
  logic [31:0] dev_base [128];
  int          hold_idx = -1, hold_left = 0, hold_seen = 0, hold_viol = 0;
  localparam int HOLD_N = 20;
  logic [35:0] snap;

  always @(negedge clock) begin
    logic wr, rdy;
    logic [36:0] cur_req;
    logic [31:0] rd;
    logic [35:0] cur_res;
    cyc++;
    if (reset) begin
      bus.m_waitrequest = 1'b0;
      bus.m_readdata    = 32'h0;
      bus.res_ready     = 1'b0;
      fifo_q.delete();
      poll_left  = 0;
      cur_rw     = 0;
      cur_dev    = '0;
      prev_stall = 0;
    end else begin
      wr = stuck_wait || (wait_pat && (cyc % 3 == 0));
      bus.m_waitrequest = wr;
      cur_req = {bus.m_write, bus.m_read, bus.m_address, bus.m_writedata};
      if (bus.m_write && bus.m_read) proto_viol++;
      if (prev_stall && cur_req !== prev_req) proto_viol++;
      prev_stall = (bus.m_write || bus.m_read) && wr;
      prev_req   = cur_req;
      rd = 32'hA5A5_A5A5;
      if (bus.m_write && !wr) begin
        bus_log.push_back({1'b1, bus.m_address, bus.m_writedata});
        case (bus.m_address)
          3'd0: cur_dev = bus.m_writedata[6:0];
          3'd2: cur_rw  = bus.m_writedata[0];
          3'd3: begin
            poll_left = 1;
            if (cur_rw) begin
              fifo_q.delete();
              for (int i = 0; i < dev_cnt[cur_dev]; i++)
                fifo_q.push_back(dev_base[cur_dev] + 32'((i + 1) * 17));
            end
          end
          default: ;
        endcase
      end
      if (bus.m_read && !wr) begin
        bus_log.push_back({1'b0, bus.m_address, 32'h0});
        case (bus.m_address)
          3'd3: begin rd = poll_left ? 32'd1 : 32'd0; poll_left = 0; end
          3'd5: rd = (!cur_rw && dev_nak[cur_dev]) ? 32'd1 : 32'd0;
          3'd6: rd = 32'(fifo_q.size());
          3'd1: rd = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'd0;
          default: rd = 32'd0;
        endcase
      end
      bus.m_readdata = rd;

      cur_res = {bus.res_slot, bus.res_last, bus.res_error, bus.res_data};
      rdy = 1'b1;
      if (bus.res_valid && res_acc == hold_idx && hold_left > 0) begin
        if (hold_left == HOLD_N) snap = cur_res;
        else if (cur_res !== snap) hold_viol++;
        if (bus.m_read || bus.m_write) hold_viol++;
        hold_left--;
        hold_seen++;
        rdy = 1'b0;
      end else if (bus.res_valid && res_acc == hold_idx && hold_seen > 0 && cur_res !== snap) begin
        hold_viol++;
      end
      bus.res_ready = rdy;
      if (bus.res_valid && rdy) begin
        res_log.push_back({2'b00, cur_res});
        res_acc++;
      end
      if (round_done) rd_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input int s, input logic [6:0] a, input logic [7:0] rg, input logic [7:0] nb);
    cfg_we = 1'b1; cfg_slot = 2'(s); cfg_addr = a; cfg_reg = rg; cfg_nbytes = nb;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic clear_table();
    for (int s = 0; s < 4; s++) cfg_write(s, 7'h0, 8'h0, 8'h0);
  endtask

  task automatic clear_logs();
    bus_log.delete(); res_log.delete(); exp_bus_q.delete(); exp_res_q.delete();
    rd_cnt = 0; res_acc = 0;
  endtask

  function automatic logic [W-1:0] wr_e(input logic [2:0] ad, input logic [31:0] d);
    return {1'b1, ad, d};
  endfunction

  function automatic logic [W-1:0] rd_e(input logic [2:0] ad);
    return {1'b0, ad, 32'h0};
  endfunction

  // Expected bus transfers and result words for one enabled slot.
  task automatic expect_slot(input int s, input logic [6:0] a, input logic [7:0] rg, input logic [7:0] nb,
                             input bit nak, input int cnt, input logic [31:0] base);
    exp_bus_q.push_back(wr_e(3'd0, {25'd0, a}));
    exp_bus_q.push_back(wr_e(3'd2, 32'd0));
    exp_bus_q.push_back(wr_e(3'd1, {24'd0, rg}));
    exp_bus_q.push_back(wr_e(3'd4, 32'd1));
    exp_bus_q.push_back(wr_e(3'd3, 32'd1));
    exp_bus_q.push_back(rd_e(3'd3));
    exp_bus_q.push_back(rd_e(3'd3));
    exp_bus_q.push_back(rd_e(3'd5));
    if (nak) begin
      exp_res_q.push_back({2'b00, 2'(s), 1'b1, 1'b1, 32'd0});
      return;
    end
    exp_bus_q.push_back(wr_e(3'd2, 32'd1));
    exp_bus_q.push_back(wr_e(3'd4, {24'd0, nb}));
    exp_bus_q.push_back(wr_e(3'd3, 32'd1));
    exp_bus_q.push_back(rd_e(3'd3));
    exp_bus_q.push_back(rd_e(3'd3));
    exp_bus_q.push_back(rd_e(3'd5));
    exp_bus_q.push_back(rd_e(3'd6));
    for (int i = 0; i < cnt; i++) begin
      exp_bus_q.push_back(rd_e(3'd1));
      exp_res_q.push_back({2'b00, 2'(s), (i == cnt - 1), 1'b0, base + 32'((i + 1) * 17)});
    end
  endtask

  task automatic run_rounds(input int n);
    int guard;
    enable = 1'b1;
    guard = 0;
    while (rd_cnt < n && guard < 4000) begin tick(); guard++; end
    enable = 1'b0;
    check("round_done_seen", 64'(rd_cnt >= n), 64'd1);
    guard = 0;
    while (busy && guard < 4000) begin tick(); guard++; end
    check("back_to_idle", 64'(busy), 64'd0);
  endtask

  task automatic cmp_logs(input string tag);
    check({tag, "_bus_len"}, 64'(bus_log.size()), 64'(exp_bus_q.size()));
    for (int i = 0; i < bus_log.size() && i < exp_bus_q.size(); i++)
      check($sformatf("%s_bus[%0d]", tag, i), 64'(bus_log[i]), 64'(exp_bus_q[i]));
    check({tag, "_res_len"}, 64'(res_log.size()), 64'(exp_res_q.size()));
    for (int i = 0; i < res_log.size() && i < exp_res_q.size(); i++)
      check($sformatf("%s_res[%0d]", tag, i), 64'(res_log[i]), 64'(exp_res_q[i]));
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int          slot;
    logic [6:0]  addr;
    logic [7:0]  rg;
    logic [7:0]  nb;
    bit          nak;
    int          cnt;
    logic [31:0] base;
    int          exp_nbus;
    int          exp_nres;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int guard, n;
    vecs[0] = '{0, 7'h48, 8'h00, 8'd2,   1'b0, 2, 32'h000, 17, 2};
    vecs[1] = '{1, 7'h50, 8'h10, 8'd1,   1'b1, 1, 32'h100,  8, 1};
    vecs[2] = '{3, 7'h1A, 8'h05, 8'd2,   1'b0, 4, 32'h300, 19, 4};
    vecs[3] = '{2, 7'h20, 8'h7F, 8'd3,   1'b0, 0, 32'h200, 15, 0};
    vecs[4] = '{1, 7'h77, 8'hFF, 8'd255, 1'b0, 1, 32'h700, 16, 1};
    for (int i = 0; i < 128; i++) begin dev_cnt[i] = 0; dev_nak[i] = 0; dev_base[i] = 32'h0; end

    reset = 1'b1; enable = 1'b0; cfg_we = 1'b0;
    cfg_slot = '0; cfg_addr = '0; cfg_reg = '0; cfg_nbytes = '0;
    repeat (3) tick();
    check("rst_m_write", 64'(bus.m_write), 64'd0);
    check("rst_m_read", 64'(bus.m_read), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_round_done", 64'(round_done), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    reset = 1'b0;
    tick();

    // Empty table after reset: a round runs with no bus traffic.
    clear_logs();
    run_rounds(1);
    cmp_logs("empty");

    for (int v = 0; v < 5; v++) begin
      clear_table();
      cfg_write(vecs[v].slot, vecs[v].addr, vecs[v].rg, vecs[v].nb);
      dev_cnt[vecs[v].addr]  = vecs[v].cnt;
      dev_nak[vecs[v].addr]  = vecs[v].nak;
      dev_base[vecs[v].addr] = vecs[v].base;
      clear_logs();
      expect_slot(vecs[v].slot, vecs[v].addr, vecs[v].rg, vecs[v].nb, vecs[v].nak, vecs[v].cnt, vecs[v].base);
      run_rounds(1);
      repeat (5) tick();
      check($sformatf("v%0d_nbus", v), 64'(bus_log.size()), 64'(vecs[v].exp_nbus));
      check($sformatf("v%0d_nres", v), 64'(res_log.size()), 64'(vecs[v].exp_nres));
      check($sformatf("v%0d_rounds", v), 64'(rd_cnt), 64'd1);
      cmp_logs($sformatf("v%0d", v));
    end

    // Slots 0 and 2 enabled, 1 and 3 disabled.
    clear_table();
    cfg_write(0, 7'h48, 8'h00, 8'd2);
    cfg_write(2, 7'h22, 8'h33, 8'd1);
    dev_cnt[7'h48] = 2; dev_base[7'h48] = 32'h0;
    dev_cnt[7'h22] = 1; dev_base[7'h22] = 32'h2200;
    clear_logs();
    expect_slot(0, 7'h48, 8'h00, 8'd2, 1'b0, 2, 32'h0);
    expect_slot(2, 7'h22, 8'h33, 8'd1, 1'b0, 1, 32'h2200);
    run_rounds(1);
    cmp_logs("sparse");

    // Back-pressure on the second word for 20 cycles.
    clear_table();
    cfg_write(0, 7'h48, 8'h00, 8'd3);
    dev_cnt[7'h48] = 3;
    clear_logs();
    hold_idx = 1; hold_left = HOLD_N; hold_seen = 0; hold_viol = 0;
    expect_slot(0, 7'h48, 8'h00, 8'd3, 1'b0, 3, 32'h0);
    run_rounds(1);
    check("hold_cycles", 64'(hold_seen), 64'(HOLD_N));
    check("hold_stable_quiet", 64'(hold_viol), 64'd0);
    cmp_logs("hold");
    hold_idx = -1;

    // Round longer than the poll period: rounds run back to back.
    clear_table();
    for (int s = 0; s < 4; s++) begin
      cfg_write(s, 7'(7'h48 + s), 8'(s), 8'd2);
      dev_cnt[7'h48 + s] = 2;
      dev_base[7'h48 + s] = 32'(s) << 12;
    end
    clear_logs();
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < 4; s++) expect_slot(s, 7'(7'h48 + s), 8'(s), 8'd2, 1'b0, 2, 32'(s) << 12);
    enable = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      guard = 0;
      while (rd_cnt < r && guard < 4000) begin tick(); guard++; end
      check($sformatf("b2b_round%0d_done", r), 64'(rd_cnt), 64'(r));
      if (r == 3) enable = 1'b0;
      else begin
        tick();
        check($sformatf("b2b_restart%0d", r), 64'(busy), 64'd1);
      end
    end
    guard = 0;
    while (busy && guard < 4000) begin tick(); guard++; end
    repeat (60) tick();
    check("b2b_rounds", 64'(rd_cnt), 64'd3);
    cmp_logs("b2b");
    check("protocol_ok", 64'(proto_viol), 64'd0);

    // Waitrequest stuck high.
    clear_table();
    cfg_write(0, 7'h48, 8'h00, 8'd1);
    stuck_wait = 1;
    enable = 1'b1;
    guard = 0;
    while (!(bus.m_write && bus.m_waitrequest) && guard < 500) begin tick(); guard++; end
    check("stall_started", 64'(bus.m_write), 64'd1);
    n = 1;
    while (n < 16) begin tick(); n++; end
    check("timeout_before_limit", 64'(timeout_err), 64'd0);
    tick();
    check("timeout_at_limit", 64'(timeout_err), 64'd1);
    repeat (30) tick();
    check("timeout_sticky", 64'(timeout_err), 64'd1);
    check("still_requesting", 64'({bus.m_write, bus.m_address}), 64'({1'b1, 3'd0}));
    reset = 1'b1;
    #1;
    check("reset_drops_req", 64'(bus.m_write), 64'd0);
    check("reset_clears_timeout", 64'(timeout_err), 64'd0);
    stuck_wait = 0;
    enable = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("post_reset_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
